// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared codes for the parametrised UART: parity modes, TX/RX
//                state encodings and frame-length helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    localparam logic [1:0] TX_IDLE = 2'd0;
    localparam logic [1:0] TX_PEND = 2'd1;
    localparam logic [1:0] TX_SEND = 2'd2;

    localparam logic [2:0] RX_INIT  = 3'd0;
    localparam logic [2:0] RX_IDLE  = 3'd1;
    localparam logic [2:0] RX_START = 3'd2;
    localparam logic [2:0] RX_RECV  = 3'd3;
    localparam logic [2:0] RX_DONE  = 3'd4;

    // Number of mid-bit samples the receiver takes after the start bit:
    // data bits, optional parity bit and the first stop bit.
    function automatic int rx_samples(input int data_w, input int parity);
        return data_w + ((parity != PARITY_NONE) ? 1 : 0) + 1;
    endfunction

    // Number of bits the transmitter shifts out after the start bit.
    function automatic int tx_payload(input int data_w, input int parity, input int stop_bits);
        return data_w + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baudgen.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baudgen
//  Description : Phase-accumulator baud generator. bit8x is the accumulator
//                carry (one clk wide); bit1x marks every eighth bit8x.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_baudgen #(
    parameter int ACC_W = 20,
    parameter int INCR  = 3221
) (
    input  logic clk,
    input  logic rst_n,
    output logic o_bit8x,
    output logic o_bit1x
);

    localparam logic [ACC_W:0] c_INCR = (ACC_W+1)'(INCR);

    logic [ACC_W-1:0] r_acc;
    logic             r_bit8x;
    logic [2:0]       r_div8;
    logic [ACC_W:0]   w_sum;

    assign w_sum = {1'b0, r_acc} + c_INCR;

    // Accumulate phase, register the carry as the 8x tick and count ticks mod 8.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_bit8x <= 1'b0;
            r_div8  <= 3'd0;
        end else begin
            r_acc   <= w_sum[ACC_W-1:0];
            r_bit8x <= w_sum[ACC_W];
            if (r_bit8x) begin
                r_div8 <= r_div8 + 3'd1;
            end
        end
    end

    assign o_bit8x = r_bit8x;
    assign o_bit1x = r_bit8x & (r_div8 == 3'd7);

endmodule
`default_nettype wire

// File: rtl/uart_param.sv
`default_nettype none
// ============================================================================
//  Module      : uart_param
//  Description : Parametrised full-duplex UART (data width, parity, stop bits)
//                with start-bit validation, parity/framing/overrun/break
//                detection and a held rx valid/ack handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_param
    import uart_pkg::*;
#(
    parameter int ACC_W     = 20,
    parameter int INCR      = 3221,
    parameter int DATA_W    = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] txdin,
    input  logic              txgo,
    output logic              txrdy,
    output logic              txd,
    input  logic              rxd,
    output logic [DATA_W-1:0] rxdout,
    output logic              rxvalid,
    input  logic              rxack,
    output logic              rxperr,
    output logic              rxferr,
    output logic              rxovr,
    output logic              rxbrk
);

    localparam int c_TX_LEN = tx_payload(DATA_W, PARITY, STOP_BITS);
    localparam int c_RX_N   = rx_samples(DATA_W, PARITY);

    logic w_bit8x;
    logic w_bit1x;

    uart_baudgen #(
        .ACC_W (ACC_W),
        .INCR  (INCR)
    ) u_baudgen (
        .clk     (clk),
        .rst_n   (rst_n),
        .o_bit8x (w_bit8x),
        .o_bit1x (w_bit1x)
    );

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    logic [1:0]          r_tx_state;
    logic [c_TX_LEN-1:0] r_tx_sh;
    logic [3:0]          r_tx_cnt;
    logic                r_txd;
    logic [c_TX_LEN-1:0] w_tx_frame;
    logic                w_txrdy;

    // Payload after the start bit: data LSB first, optional parity, stop bits.
    generate
        if (PARITY != PARITY_NONE) begin : g_tx_par
            logic w_tx_par;
            assign w_tx_par   = (PARITY == PARITY_ODD) ? ~(^txdin) : (^txdin);
            assign w_tx_frame = {{STOP_BITS{1'b1}}, w_tx_par, txdin};
        end else begin : g_tx_nopar
            assign w_tx_frame = {{STOP_BITS{1'b1}}, txdin};
        end
    endgenerate

    // Ready while idle or while the final stop bit is on the line, so a
    // new load can follow back-to-back with no idle gap.
    assign w_txrdy = (r_tx_state == TX_IDLE) ||
                     ((r_tx_state == TX_SEND) && (r_tx_cnt == 4'd0));

    // Load on txgo, then step one bit per bit1x: PEND -> start -> payload.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tx_state <= TX_IDLE;
            r_tx_sh    <= '0;
            r_tx_cnt   <= 4'd0;
            r_txd      <= 1'b1;
        end else if (txgo && w_txrdy) begin
            r_tx_sh    <= w_tx_frame;
            r_tx_state <= TX_PEND;
        end else if (w_bit1x) begin
            case (r_tx_state)
                TX_PEND: begin
                    r_txd      <= 1'b0;
                    r_tx_cnt   <= 4'(c_TX_LEN);
                    r_tx_state <= TX_SEND;
                end
                TX_SEND: begin
                    if (r_tx_cnt != 4'd0) begin
                        r_txd    <= r_tx_sh[0];
                        r_tx_sh  <= {1'b1, r_tx_sh[c_TX_LEN-1:1]};
                        r_tx_cnt <= r_tx_cnt - 4'd1;
                    end else begin
                        r_txd      <= 1'b1;
                        r_tx_state <= TX_IDLE;
                    end
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

    assign txrdy = w_txrdy;
    assign txd   = r_txd;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic [1:0]        r_rx_sync;
    logic [2:0]        r_rx_state;
    logic [2:0]        r_rx_sub;
    logic [3:0]        r_rx_cnt;
    logic [c_RX_N-1:0] r_rx_sh;
    logic [DATA_W-1:0] r_rxdout;
    logic              r_rxvalid;
    logic              r_rxperr;
    logic              r_rxferr;
    logic              r_rxovr;
    logic              r_rxbrk;
    logic              w_din;
    logic              w_rx_stop;
    logic              w_rx_brk;
    logic              w_rx_perr;

    assign w_din     = r_rx_sync[1];
    assign w_rx_stop = r_rx_sh[c_RX_N-1];
    assign w_rx_brk  = (r_rx_sh == '0);

    // Parity error: odd mode wants an odd count of ones over data+parity.
    generate
        if (PARITY == PARITY_ODD) begin : g_rx_odd
            assign w_rx_perr = ~(^r_rx_sh[DATA_W:0]);
        end else if (PARITY == PARITY_EVEN) begin : g_rx_even
            assign w_rx_perr = ^r_rx_sh[DATA_W:0];
        end else begin : g_rx_nopar
            assign w_rx_perr = 1'b0;
        end
    endgenerate

    // Synchronise rxd, walk the frame at mid-bit samples, publish in DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rx_sync  <= 2'b11;
            r_rx_state <= RX_INIT;
            r_rx_sub   <= 3'd0;
            r_rx_cnt   <= 4'd0;
            r_rx_sh    <= '0;
            r_rxdout   <= '0;
            r_rxvalid  <= 1'b0;
            r_rxperr   <= 1'b0;
            r_rxferr   <= 1'b0;
            r_rxovr    <= 1'b0;
            r_rxbrk    <= 1'b0;
        end else begin
            r_rxbrk <= 1'b0;
            if (w_bit8x) begin
                r_rx_sync <= {r_rx_sync[0], rxd};
            end
            case (r_rx_state)
                RX_INIT: begin
                    if (w_bit8x && w_din) begin
                        r_rx_state <= RX_IDLE;
                    end
                end
                RX_IDLE: begin
                    if (w_bit8x && !w_din) begin
                        r_rx_sub   <= 3'd0;
                        r_rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (w_bit8x) begin
                        r_rx_sub <= r_rx_sub + 3'd1;
                        if (r_rx_sub == 3'd3) begin
                            r_rx_cnt   <= 4'd0;
                            r_rx_state <= w_din ? RX_IDLE : RX_RECV;
                        end
                    end
                end
                RX_RECV: begin
                    if (w_bit8x) begin
                        r_rx_sub <= r_rx_sub + 3'd1;
                        if (r_rx_sub == 3'd3) begin
                            r_rx_sh  <= {w_din, r_rx_sh[c_RX_N-1:1]};
                            r_rx_cnt <= r_rx_cnt + 4'd1;
                            if (r_rx_cnt == 4'(c_RX_N - 1)) begin
                                r_rx_state <= RX_DONE;
                            end
                        end
                    end
                end
                RX_DONE: begin
                    // A low stop bit means the line may still be held low:
                    // wait for it to return high before hunting for a start.
                    r_rx_state <= w_rx_stop ? RX_IDLE : RX_INIT;
                    r_rxbrk    <= w_rx_brk;
                    if (r_rxvalid && !rxack) begin
                        r_rxovr <= 1'b1;
                    end else begin
                        r_rxdout  <= r_rx_sh[DATA_W-1:0];
                        r_rxperr  <= w_rx_perr;
                        r_rxferr  <= ~w_rx_stop;
                        r_rxvalid <= 1'b1;
                        r_rxovr   <= 1'b0;
                    end
                end
                default: r_rx_state <= RX_INIT;
            endcase
            if ((r_rx_state != RX_DONE) && rxack && r_rxvalid) begin
                r_rxvalid <= 1'b0;
                r_rxovr   <= 1'b0;
            end
        end
    end

    assign rxdout  = r_rxdout;
    assign rxvalid = r_rxvalid;
    assign rxperr  = r_rxperr;
    assign rxferr  = r_rxferr;
    assign rxovr   = r_rxovr;
    assign rxbrk   = r_rxbrk;

endmodule
`default_nettype wire
